// File: rtl/training_sequencer.sv
// training_sequencer: steps each sample through ADVANCE, LOAD (image stream), FORWARD, BACKWARD
// and UPDATE for a latched number of epochs. Define LABEL_CHECK_EN for the sticky label_err flag.
module training_sequencer #(
  parameter  int unsigned IMG_SIZE    = 256,
  parameter  int unsigned CLASSES     = 10,
  parameter  int unsigned NUM_SAMPLES = 512,
  localparam int unsigned ADDR_W      = $clog2(IMG_SIZE * NUM_SAMPLES),
  localparam int unsigned CNT_W       = $clog2(IMG_SIZE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         num_epochs,
  input  logic               fwd_done,
  input  logic               bwd_done,
  input  logic               upd_done,
  input  logic [7:0]         label_in,
  output logic [2:0]         curr_state,
  output logic [ADDR_W-1:0]  pixel_addr,
  output logic               pixel_valid,
  output logic               fwd_start,
  output logic               bwd_start,
  output logic               upd_start,
  output logic [CLASSES-1:0] target,
  output logic [8:0]         sample_idx,
  output logic [7:0]         epoch,
  output logic               busy,
  output logic               done,
  output logic               label_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    LOAD     = 3'b001,
    ADVANCE  = 3'b010,
    FORWARD  = 3'b011,
    BACKWARD = 3'b100,
    UPDATE   = 3'b101,
    DONE     = 3'b110
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [8:0]         sample_q, sample_d;
  logic [7:0]         epoch_q, epoch_d;
  logic [7:0]         epochs_q, epochs_d;
  logic [CLASSES-1:0] target_q, target_d;
  logic [CLASSES-1:0] label_oh;
  logic               err_q, err_d;
  logic               fwd_start_q, fwd_start_d;
  logic               bwd_start_q, bwd_start_d;
  logic               upd_start_q, upd_start_d;

  // Out-of-range labels match no class and decode to all-zero.
  always_comb begin
    label_oh = '0;
    for (int unsigned i = 0; i < CLASSES; i++) begin
      label_oh[i] = (label_in == 8'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    sample_d = sample_q;
    epoch_d  = epoch_q;
    epochs_d = epochs_q;
    target_d = target_q;
    err_d    = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          epochs_d = (num_epochs == 8'd0) ? 8'd1 : num_epochs;
          sample_d = '0;
          epoch_d  = '0;
          err_d    = 1'b0;
          state_d  = ADVANCE;
        end
      end
      ADVANCE: begin
        cnt_d   = '0;
        addr_d  = ADDR_W'(sample_q) * ADDR_W'(IMG_SIZE);
        state_d = LOAD;
      end
      LOAD: begin
        // Label RAM read data is valid one cycle after the ADVANCE edge.
        if (cnt_q == CNT_W'(1)) begin
          target_d = label_oh;
`ifdef LABEL_CHECK_EN
          if (32'(label_in) >= CLASSES) err_d = 1'b1;
`endif
        end
        if (cnt_q == CNT_W'(IMG_SIZE - 1)) begin
          state_d = FORWARD;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      FORWARD:  if (fwd_done) state_d = BACKWARD;
      BACKWARD: if (bwd_done) state_d = UPDATE;
      UPDATE: begin
        if (upd_done) begin
          if (sample_q != 9'(NUM_SAMPLES - 1)) begin
            sample_d = sample_q + 9'd1;
            state_d  = ADVANCE;
          end else begin
            sample_d = '0;
            if (epoch_q == epochs_q - 8'd1) begin
              state_d = DONE;
            end else begin
              epoch_d = epoch_q + 8'd1;
              state_d = ADVANCE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fwd_start_d = (state_d == FORWARD)  && (state_q != FORWARD);
    bwd_start_d = (state_d == BACKWARD) && (state_q != BACKWARD);
    upd_start_d = (state_d == UPDATE)   && (state_q != UPDATE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      sample_q    <= '0;
      epoch_q     <= '0;
      epochs_q    <= '0;
      target_q    <= '0;
      err_q       <= 1'b0;
      fwd_start_q <= 1'b0;
      bwd_start_q <= 1'b0;
      upd_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      sample_q    <= sample_d;
      epoch_q     <= epoch_d;
      epochs_q    <= epochs_d;
      target_q    <= target_d;
      err_q       <= err_d;
      fwd_start_q <= fwd_start_d;
      bwd_start_q <= bwd_start_d;
      upd_start_q <= upd_start_d;
    end
  end

  assign curr_state  = state_q;
  assign pixel_addr  = addr_q;
  assign pixel_valid = (state_q == LOAD);
  assign fwd_start   = fwd_start_q;
  assign bwd_start   = bwd_start_q;
  assign upd_start   = upd_start_q;
  assign target      = target_q;
  assign sample_idx  = sample_q;
  assign epoch       = epoch_q;
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign done        = (state_q == DONE);
  assign label_err   = err_q;

endmodule

// File: tb/tb_training_sequencer.sv
// Bench for training_sequencer: lock-step transaction model (epochs x samples x phases) with
// randomized labels, engine latencies and stray inputs, checked by immediate assertions.
module tb_training_sequencer;

  localparam int unsigned IMG = 256;
  localparam int unsigned NS  = 4;
  localparam int unsigned CL  = 10;
  localparam int unsigned AW  = $clog2(IMG * NS);

  localparam logic [2:0] S_IDLE = 3'b000, S_LOAD = 3'b001, S_ADV = 3'b010, S_FWD = 3'b011,
                         S_BWD  = 3'b100, S_UPD  = 3'b101, S_DONE = 3'b110;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    num_epochs = '0;
  logic          fwd_done = 1'b0, bwd_done = 1'b0, upd_done = 1'b0;
  logic [7:0]    label_in = '0;
  logic [2:0]    curr_state;
  logic [AW-1:0] pixel_addr;
  logic          pixel_valid, fwd_start, bwd_start, upd_start;
  logic [CL-1:0] target;
  logic [8:0]    sample_idx;
  logic [7:0]    epoch;
  logic          busy, done, label_err;

  int            n_checks = 0;
  int            n_errors = 0;
  int unsigned   labels[NS];
  int            cur_s = 0, cur_ep = 0;
  logic [CL-1:0] exp_target = '0;
  logic          exp_err = 1'b0;

  training_sequencer #(.IMG_SIZE(IMG), .CLASSES(CL), .NUM_SAMPLES(NS)) dut (
    .clk(clk), .rst(rst), .start(start), .num_epochs(num_epochs),
    .fwd_done(fwd_done), .bwd_done(bwd_done), .upd_done(upd_done), .label_in(label_in),
    .curr_state(curr_state), .pixel_addr(pixel_addr), .pixel_valid(pixel_valid),
    .fwd_start(fwd_start), .bwd_start(bwd_start), .upd_start(upd_start), .target(target),
    .sample_idx(sample_idx), .epoch(epoch), .busy(busy), .done(done), .label_err(label_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CL-1:0] onehot(input int unsigned l);
    onehot = (l < CL) ? (CL'(1) << l) : '0;
  endfunction

  task automatic expect_cycle(input string tag, input logic [2:0] st, input logic pv,
                              input logic [AW-1:0] addr, input logic fs, input logic bs,
                              input logic us);
    chk({tag, ".state"}, curr_state, st);
    chk({tag, ".busy"}, busy, (st != S_IDLE) && (st != S_DONE));
    chk({tag, ".done"}, done, st == S_DONE);
    chk({tag, ".pv"}, pixel_valid, pv);
    if (pv) chk({tag, ".addr"}, pixel_addr, addr);
    chk({tag, ".fwd_start"}, fwd_start, fs);
    chk({tag, ".bwd_start"}, bwd_start, bs);
    chk({tag, ".upd_start"}, upd_start, us);
    chk({tag, ".sample"}, sample_idx, cur_s);
    chk({tag, ".epoch"}, epoch, cur_ep);
    chk({tag, ".target"}, target, exp_target);
    chk({tag, ".label_err"}, label_err, exp_err);
  endtask

  task automatic clear_inputs();
    start = 1'b0; fwd_done = 1'b0; bwd_done = 1'b0; upd_done = 1'b0;
  endtask

  // Idle cycles with engine dones asserted: no start pulse may appear.
  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      expect_cycle(tag, S_IDLE, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      fwd_done = 1'b1; bwd_done = 1'b1; upd_done = 1'b1;
      tick();
    end
    clear_inputs();
  endtask

  task automatic reset_abort(input string tag);
    #2 rst = 1'b0;
    #1;
    cur_s = 0; cur_ep = 0; exp_target = '0; exp_err = 1'b0;
    expect_cycle({tag, ".rst"}, S_IDLE, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk({tag, ".rst.addr"}, pixel_addr, 0);
    clear_inputs();
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    idle_cycles({tag, ".post_rst"}, 4);
  endtask

  // One engine phase: matching done after d cycles, strays on the other done lines and start.
  task automatic phase(input string tag, input logic [2:0] st, input int d);
    for (int j = 0; j <= d; j++) begin
      expect_cycle(tag, st, 1'b0, '0, (st == S_FWD) && (j == 0), (st == S_BWD) && (j == 0),
                   (st == S_UPD) && (j == 0));
      fwd_done = (st == S_FWD) ? (j == d) : ((j % 2) == 1);
      bwd_done = (st == S_BWD) ? (j == d) : ((j % 2) == 1);
      upd_done = (st == S_UPD) ? (j == d) : ((j % 2) == 1);
      start    = ((j % 3) == 2);
      tick();
    end
    clear_inputs();
  endtask

  task automatic run(input string tag, input int ne, input int abort_k, input bit fixed);
    int eff;
    eff = (ne == 0) ? 1 : ne;
    num_epochs = 8'(ne);
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_err = 1'b0;
    for (int ep = 0; ep < eff; ep++) begin
      for (int s = 0; s < int'(NS); s++) begin
        cur_s = s; cur_ep = ep;
        expect_cycle({tag, ".adv"}, S_ADV, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        label_in = 8'($urandom_range(0, 255));
        tick();
        for (int k = 0; k < int'(IMG); k++) begin
          if (k == 2) begin
            exp_target = onehot(labels[s]);
`ifdef LABEL_CHECK_EN
            if (labels[s] >= CL) exp_err = 1'b1;
`endif
          end
          expect_cycle({tag, ".load"}, S_LOAD, 1'b1, AW'(s * int'(IMG) + k), 1'b0, 1'b0, 1'b0);
          if (ep == 0 && s == 0 && k == abort_k) begin
            reset_abort(tag);
            return;
          end
          label_in = (k == 1) ? 8'(labels[s]) : 8'($urandom_range(0, 255));
          if (!fixed) begin
            fwd_done = ($urandom_range(0, 7) == 0);
            bwd_done = ($urandom_range(0, 7) == 0);
            upd_done = ($urandom_range(0, 7) == 0);
            start    = ($urandom_range(0, 7) == 0);
          end
          tick();
        end
        clear_inputs();
        phase({tag, ".fwd"}, S_FWD, fixed ? 5 : int'($urandom_range(0, 6)));
        phase({tag, ".bwd"}, S_BWD, fixed ? 0 : int'($urandom_range(0, 6)));
        phase({tag, ".upd"}, S_UPD, fixed ? 17 : int'($urandom_range(0, 6)));
      end
    end
    cur_s = 0; cur_ep = eff - 1;
    for (int j = 0; j < 3; j++) begin
      expect_cycle({tag, ".done"}, S_DONE, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      fwd_done = (j == 0); bwd_done = (j == 1); upd_done = (j == 2);
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    for (int i = 0; i < int'(NS); i++) labels[i] = $urandom_range(0, CL - 1);
    tick();
    expect_cycle("reset_held", S_IDLE, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("reset_held.addr", pixel_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    idle_cycles("reset_idle", 3);

    labels[0] = 3;
    run("basic", 1, -1, 1'b1);
    run("two_epochs", 2, -1, 1'b1);
    run("abort", 1, 100, 1'b1);
    run("restart", 1, -1, 1'b1);

    labels[0] = 12; labels[1] = 1; labels[2] = 2; labels[3] = 3;
    run("bad_label", 1, -1, 1'b1);
    labels[0] = 5;
    run("clear_err", 1, -1, 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < int'(NS); i++) labels[i] = $urandom_range(0, CL + 3);
      run($sformatf("rand%0d", r), int'($urandom_range(0, 3)), -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/training_sequencer.md
TRAINING_SEQUENCER -- requirements
Module: training_sequencer

Interface
REQ-001 SHALL have parameter IMG_SIZE, default 256, pixels per sample (>=2).
REQ-002 SHALL have parameter CLASSES, default 10, output classes (<=256).
REQ-003 SHALL have parameter NUM_SAMPLES, default 512, samples per epoch; must equal 512 with the 9-bit label RAM.
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  begin training run when idle.
REQ-007 SHALL have port num_epochs  in  8  epoch count, sampled on accepted start.
REQ-008 SHALL have ports fwd_done, bwd_done, upd_done  in  1 each  engine completion pulses.
REQ-009 SHALL have port label_in  in  8  label RAM read data.
REQ-010 SHALL have port curr_state  out  3  encoded state, drives label RAM address advance.
REQ-011 SHALL have ports pixel_addr  out  clog2(IMG_SIZE*NUM_SAMPLES) and pixel_valid  out  1  image RAM read stream.
REQ-012 SHALL have ports fwd_start, bwd_start, upd_start  out  1 each  one-cycle engine start pulses.
REQ-013 SHALL have port target  out  CLASSES  one-hot label of current sample.
REQ-014 SHALL have ports sample_idx  out  9, epoch  out  8, busy  out  1, done  out  1, label_err  out  1.

Function
REQ-015 SHALL encode states IDLE=000, LOAD=001, ADVANCE=010, FORWARD=011, BACKWARD=100, UPDATE=101, DONE=110 on curr_state.
REQ-016 IDLE: start=1 SHALL latch num_epochs (0 treated as 1), clear sample_idx/epoch, go ADVANCE; start in any other state SHALL be ignored.
REQ-017 ADVANCE SHALL last exactly one cycle, then LOAD.
REQ-018 LOAD SHALL last exactly IMG_SIZE cycles, pixel_valid=1 each cycle, pixel_addr = sample_idx*IMG_SIZE + k for cycle k=0..IMG_SIZE-1.
REQ-019 label_in SHALL be captured at the end of LOAD cycle k=1 (ADVANCE edge + 1-cycle RAM latency); target updates on that edge.
REQ-020 Entry to FORWARD/BACKWARD/UPDATE SHALL pulse fwd_start/bwd_start/upd_start for exactly the first cycle of that state.
REQ-021 FORWARD->BACKWARD on fwd_done; BACKWARD->UPDATE on bwd_done; done pulses arriving in other states SHALL be ignored; a done coincident with the start pulse SHALL be accepted.
REQ-022 UPDATE on upd_done: if sample_idx<NUM_SAMPLES-1, increment sample_idx, go ADVANCE; else sample_idx wraps to 0, epoch increments, go DONE if epoch reached latched count-1, else ADVANCE.
REQ-023 DONE SHALL hold done=1, busy=0 until start=1, which behaves as in REQ-016.
REQ-024 busy SHALL be 1 in every state except IDLE and DONE; pixel_valid SHALL be 0 outside LOAD.
REQ-025 Exactly one ADVANCE SHALL occur per sample so label RAM address tracks sample_idx (wraps 511->0 together).

Reset
REQ-026 rst=0 SHALL asynchronously force IDLE, curr_state=000, all pulses/pixel_valid/busy/done/label_err=0, pixel_addr/sample_idx/epoch/target=0, including mid-LOAD or while awaiting engine done.
REQ-027 After reset deassertion, no engine start pulse SHALL occur until a new start is accepted.

Configuration
REQ-028 Macro LABEL_CHECK_EN defined: captured label_in>=CLASSES SHALL set target all-zero and set label_err sticky (cleared only by reset or accepted start); sequencing continues.
REQ-029 Macro LABEL_CHECK_EN undefined: label_err tied 0; target = one-hot of label_in, all-zero when label_in>=CLASSES.

Verification
REQ-030 Reset, start=1, num_epochs=1, label_in=3 -> ADVANCE 1 cycle, LOAD 256 cycles with pixel_addr 0..255, target=0000001000, fwd_start pulse next cycle.
REQ-031 Engine done pulses delayed 5, 0, 17 cycles -> one start pulse each, transitions only on matching done, stray bwd_done during FORWARD ignored.
REQ-032 NUM_SAMPLES=4 stub, num_epochs=2 -> 8 ADVANCE cycles, sample_idx 0..3 twice, epoch 0->1, DONE after eighth upd_done, done=1.
REQ-033 rst=0 asserted at LOAD k=100 -> outputs zero same cycle; restart gives pixel_addr from 0 again.
REQ-034 LABEL_CHECK_EN, label_in=12 -> target=0, label_err=1 and held across subsequent samples until next start.
